mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous-read memory port between instruction fetch (IF) and the EX/MEM data path (D).
- Data requests win by default; a starvation counter forces an IF grant after STARVE_LIMIT consecutive denials.
- Tracks the single outstanding read and routes its data back to the owning requester one cycle later.
- Exports per-requester stall flags to cpu_ctrl.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (matches `DATA_BUS).
- STARVE_LIMIT, 4, consecutive IF denials after which IF gets priority for one grant.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  IF read request; held until granted.
- if_addr  in  ADDR_W  IF read address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  if_rdata valid; exactly one cycle after if_gnt.
- if_rdata  out  DATA_W  IF read data.
- d_req  in  1  data request; held until granted.
- d_rw  in  1  `MEM_READ or `MEM_WRITE.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_wmask  in  DATA_W/8  byte enables for writes.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid; one cycle after a read grant only.
- d_rdata  out  DATA_W  data read result.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0.
- if_stall  out  1  if_req & ~if_gnt (combinational).
- d_stall  out  1  d_req & ~d_gnt (combinational).

Behaviour:
- Reset (async): starve_cnt=0, resp_owner=NONE, all grants, rvalids and mem_en are 0; rdata outputs are 0.
- Arbitration is combinational within the request cycle. Grant rule:
  - starve_cnt==STARVE_LIMIT and if_req: IF granted.
  - else d_req: D granted.
  - else if_req: IF granted.
  - At most one grant per cycle.
- Memory drive on grant:
  - mem_en=1; mem_addr from the winner.
  - mem_we=1 only for a D grant with d_rw=`MEM_WRITE; mem_wdata/mem_wmask from D in that case, otherwise 0.
- With no grant: mem_en=0 and all mem_* outputs are 0.
- Response tracking: resp_owner register ∈ {NONE, IF, D}.
  - Set on the clock edge after a read grant.
  - A write grant or no grant sets it to NONE.
  - if_rvalid = (resp_owner==IF); d_rvalid = (resp_owner==D).
  - Both rdata outputs are fed from mem_rdata when their rvalid is set, 0 otherwise.
- Writes complete in the grant cycle and produce no rvalid.
- Back-to-back: a new grant may issue in the same cycle the previous response returns. Full throughput is one access per cycle.
- starve_cnt (saturating, width clog2(STARVE_LIMIT+1)):
  - Increments when if_req & ~if_gnt.
  - Clears when if_gnt or ~if_req.
  - Saturates at STARVE_LIMIT.
- A request dropped before its grant is simply discarded; a request withdrawn while starved clears the counter.
- Simultaneous events:
  - d_req and if_req together with the counter below the limit: D wins and the counter increments.
  - Counter at the limit: IF wins; the counter clears and D stalls one cycle.
- Reset mid-operation: a pending response is dropped (no rvalid after reset); requesters must re-issue.
- Requester contract: request fields must be stable while req=1 and gnt=0; the arbiter does not latch them.

Decomposition:
- Shared package/header (`common.v`): `MEM_READ, `MEM_WRITE, `ENABLE/`DISABLE, `DATA_BUS, `DATA_ZERO, plus new localparam encodings OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2.
- One natural sub-module: starve_counter (saturating counter with inc/clr/at_limit).
- Grant logic and response tracking stay in the top module.

Test Plan:
- Only if_req, addr 0x100, mem returns 0xDEADBEEF → if_gnt same cycle, if_rvalid=1 with if_rdata=0xDEADBEEF next cycle, d_rvalid=0.
- Both requesting, D read 0x200 → d_gnt=1, if_gnt=0, if_stall=1, d_rvalid next cycle; starve_cnt=1.
- d_req held continuously with if_req held → IF granted on the 5th contention cycle (STARVE_LIMIT=4); that cycle d_stall=1, then D resumes.
- D write to 0x40 with data 0x12345678, mask 4'b0011 → mem_we=1, mem_wmask=0011, no d_rvalid next cycle.
- Alternating IF read / D read every cycle → one grant per cycle, each rvalid routed to the correct owner with no lost or duplicated responses.
- rst asserted the cycle after an IF read grant → if_rvalid stays 0, all outputs 0 immediately (asynchronously), counter 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// Imported by the arbiter, its interface and its sub-modules.
package mem_port_arbiter_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;

    localparam int DATA_BUS = 32;
    localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

    // Owner of the single outstanding read response
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    // One-hot arbitration result for the current cycle
    typedef struct packed {
        logic if_win;
        logic d_win;
    } grant_t;

    // Bits needed to count from 0 up to and including limit
    function automatic int cnt_width(input int limit);
        if (limit < 1) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bundle of the port arbiter.
// master = requesters plus memory, slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_rw;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wmask;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  if_stall;
    logic                  d_stall;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_rw, d_addr, d_wdata, d_wmask,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata,
        input  if_stall, d_stall
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_rw, d_addr, d_wdata, d_wmask,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata,
        output if_stall, d_stall
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive instruction-fetch denials.
// o_at_limit hands the next grant to instruction fetch.
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int CW = cnt_width(LIMIT);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == LIM);
    assign o_at_limit = w_at_limit;

    // Clear wins over increment; hold once the limit is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch and data.
// Data wins by default; a starvation counter forces a fetch grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int MASK_W = DATA_W / 8;

    grant_t              w_gnt;
    logic                w_at_limit;
    logic                w_cnt_inc;
    logic                w_cnt_clr;
    logic                w_d_write;
    logic [1:0]          w_owner_nxt;
    logic [1:0]          r_owner;

    logic                w_mem_en;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [MASK_W-1:0]   w_mem_wmask;

    assign w_d_write = (bus.d_rw == MEM_WRITE);

    // Pick at most one winner; nothing is granted while in reset
    always_comb begin
        w_gnt = '0;
        if (!rst) begin
            if (bus.if_req && w_at_limit) begin
                w_gnt.if_win = 1'b1;
            end else if (bus.d_req) begin
                w_gnt.d_win = 1'b1;
            end else if (bus.if_req) begin
                w_gnt.if_win = 1'b1;
            end
        end
    end

    // Steer the winner onto the memory port, zero when idle
    always_comb begin
        w_mem_en    = DISABLE;
        w_mem_we    = DISABLE;
        w_mem_addr  = '0;
        w_mem_wdata = DATA_ZERO;
        w_mem_wmask = '0;
        if (w_gnt.if_win) begin
            w_mem_en   = ENABLE;
            w_mem_addr = bus.if_addr;
        end else if (w_gnt.d_win) begin
            w_mem_en   = ENABLE;
            w_mem_addr = bus.d_addr;
            if (w_d_write) begin
                w_mem_we    = ENABLE;
                w_mem_wdata = bus.d_wdata;
                w_mem_wmask = bus.d_wmask;
            end
        end
    end

    // Read grants own next cycle's response; writes and idle own none
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_gnt.if_win) begin
            w_owner_nxt = OWN_IF;
        end else if (w_gnt.d_win && !w_d_write) begin
            w_owner_nxt = OWN_D;
        end
    end

    // Response owner; reset drops any response still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    assign w_cnt_inc = bus.if_req & ~w_gnt.if_win;
    assign w_cnt_clr = w_gnt.if_win | ~bus.if_req;

    mem_port_arbiter_starve_counter #(
        .LIMIT      (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_cnt_inc),
        .i_clr      (w_cnt_clr),
        .o_at_limit (w_at_limit)
    );

    assign bus.if_gnt    = w_gnt.if_win;
    assign bus.d_gnt     = w_gnt.d_win;
    assign bus.if_stall  = bus.if_req & ~w_gnt.if_win;
    assign bus.d_stall   = bus.d_req & ~w_gnt.d_win;

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_wmask = w_mem_wmask;

    assign bus.if_rvalid = (r_owner == OWN_IF);
    assign bus.d_rvalid  = (r_owner == OWN_D);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : DATA_ZERO;
    assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : DATA_ZERO;

endmodule
